// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, sign fixup.
// Latency: out_valid 34 edges after request cycle (accept + 32 iterations + fixup); div-by-zero fast path 1.
// Backpressure: holds result/rd_out/out_valid in DONE until out_ready; in_ready only in IDLE.
module muldiv_unit #(
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [2:0]  op;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic [31:0] a_raw;
  logic [31:0] b_mag;
  logic [31:0] hi;
  logic [31:0] lo;

  // Accept-time operand decode: which operands are signed, their magnitudes, div-by-zero.
  logic        acc_signed_a;
  logic        acc_signed_b;
  logic        acc_sign_a;
  logic        acc_sign_b;
  logic [31:0] acc_a_mag;
  logic [31:0] acc_b_mag;
  logic        acc_div_zero;
  logic [31:0] zero_result;

  // Signedness per op: divides are signed when funct3[0]==0; MULHU is the only fully
  // unsigned multiply and MULHSU keeps only rs1 signed.
  always_comb begin
    acc_signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    acc_signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    acc_sign_a   = acc_signed_a & rs1_data[31];
    acc_sign_b   = acc_signed_b & rs2_data[31];
    acc_a_mag    = acc_sign_a ? (32'd0 - rs1_data) : rs1_data;
    acc_b_mag    = acc_sign_b ? (32'd0 - rs2_data) : rs2_data;
    acc_div_zero = funct3[2] & (rs2_data == 32'd0);
    zero_result  = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
  end

  assign in_ready = (state == IDLE);

  // One iteration step: multiply adds b into the high half when the multiplier LSB is set,
  // divide shifts the partial remainder left and subtracts b if it fits.
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [32:0] diff;

  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : 33'd0);
    trial   = {hi, lo[31]};
    diff    = trial - {1'b0, b_mag};
  end

  // Fixup: negate the magnitude result when needed and pick the requested half.
  logic [63:0] prod_abs;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_result;

  always_comb begin
    prod_abs   = {hi, lo};
    prod_fix   = (sign_a ^ sign_b) ? (64'd0 - prod_abs) : prod_abs;
    quot_fix   = (sign_a ^ sign_b) ? (32'd0 - lo) : lo;
    rem_fix    = sign_a ? (32'd0 - hi) : hi;
    fix_result = 32'd0;
    if (!op[2]) begin
      fix_result = (op[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end else if (div_zero) begin
      // RISC-V defined div-by-zero values bypass the sign logic entirely.
      fix_result = op[1] ? a_raw : 32'hFFFF_FFFF;
    end else begin
      fix_result = op[1] ? rem_fix : quot_fix;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 5'd0;
      op        <= 3'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      a_raw     <= 32'd0;
      b_mag     <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      out_valid <= 1'b0;
      result    <= 32'd0;
      rd_out    <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op       <= funct3;
            sign_a   <= acc_sign_a;
            sign_b   <= acc_sign_b;
            div_zero <= acc_div_zero;
            a_raw    <= rs1_data;
            b_mag    <= acc_b_mag;
            hi       <= 32'd0;
            lo       <= acc_a_mag;
            rd_out   <= rd_in;
            count    <= 5'd0;
            if (DIV_ZERO_FAST && acc_div_zero) begin
              result    <= zero_result;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!op[2]) begin
            hi <= add_sum[32:1];
            lo <= {add_sum[0], lo[31:1]};
          end else if (!diff[32]) begin
            hi <= diff[31:0];
            lo <= {lo[30:0], 1'b1};
          end else begin
            hi <= trial[31:0];
            lo <= {lo[30:0], 1'b0};
          end
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          result    <= fix_result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.DIV_ZERO_FAST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // Expected response; lat counts edges from the request cycle to out_valid,
  // including the accepting edge.
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_ov = 1'b0;

  localparam int LAT = 34;
  localparam int LAT_Z = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: checks latency when out_valid rises, pops and compares at transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          if (!prev_ov) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got result %h rd %0d, expected no output", result, rd_out);
          end
        end else begin
          if (!prev_ov) check("latency", cyc - exp_q[0].acc, exp_q[0].lat);
          if (out_ready) begin
            check("result", result, exp_q[0].res);
            check("rd_out", {27'd0, rd_out}, {27'd0, exp_q[0].rd});
            void'(exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got in_ready 0, expected 1 within 200 cycles");
      return;
    end
    in_valid = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    if (push) exp_q.push_back('{res, rd, cyc, lat});
    @(negedge clk);
    // Scramble operands after the accept so a late sample would corrupt the result.
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    funct3    = 3'd0;
    rs1_data  = 32'd0;
    rs2_data  = 32'd0;
    rd_in     = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Multiplies
    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, LAT, 1);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, LAT, 1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, LAT, 1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, LAT, 1);
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'h0000_0001, LAT, 1);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000, 5'd15, 32'h0000_0000, LAT, 1);
    issue(3'b001, 32'd7,        32'hFFFF_FFFD, 5'd20, 32'hFFFF_FFFF, LAT, 1);
    issue(3'b010, 32'd2,        32'hFFFF_FFFF, 5'd21, 32'h0000_0001, LAT, 1);
    // Divides, including signed overflow and rd=0
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,        5'd5,  32'hFFFF_FFFD, LAT, 1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,        5'd6,  32'hFFFF_FFFF, LAT, 1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, LAT, 1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0000_0000, LAT, 1);
    issue(3'b100, 32'd7,        32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, LAT, 1);
    issue(3'b110, 32'd7,        32'hFFFF_FFFE, 5'd18, 32'h0000_0001, LAT, 1);
    issue(3'b101, 32'd100,      32'd7,        5'd0,  32'd14,        LAT, 1);
    issue(3'b111, 32'd100,      32'd7,        5'd19, 32'd2,         LAT, 1);
    // Divide by zero fast path
    issue(3'b101, 32'd5,        32'd0,        5'd9,  32'hFFFF_FFFF, LAT_Z, 1);
    issue(3'b111, 32'd5,        32'd0,        5'd10, 32'd5,         LAT_Z, 1);
    issue(3'b100, 32'hFFFF_FFFB, 32'd0,        5'd11, 32'hFFFF_FFFF, LAT_Z, 1);
    issue(3'b110, 32'hFFFF_FFFB, 32'd0,        5'd12, 32'hFFFF_FFFB, LAT_Z, 1);
    drain();

    // Backpressure: hold out_ready low in DONE, pulse in_valid meanwhile.
    out_ready = 1'b0;
    issue(3'b000, 32'd6, 32'd7, 5'd17, 32'd42, LAT, 1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bp_reached_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      funct3   = 3'b000;
      rs1_data = 32'd3;
      rs2_data = 32'd3;
      rd_in    = 5'd22;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'd42);
      check("bp_rd_out", {27'd0, rd_out}, 32'd17);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();
    // A wrongly accepted pulse would surface as an unexpected result in this window.
    repeat (40) @(negedge clk);
    check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of CALC (counter=10), then a clean operation.
    issue(3'b101, 32'd100, 32'd7, 5'd23, 32'd14, LAT, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    issue(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd24, 32'hFFFF_FFF2, LAT, 1);
    issue(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd25, 32'hFFFF_FFFE, LAT, 1);
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
